// File: rtl/floors_pkg.sv
// Shared constants, types and the LFSR step function for the scrolling floor field.
package floors_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t FLOOR_RGB = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam rgb_t BG_RGB    = '{r: 3'd0, g: 3'd0, b: 2'd0};

  typedef enum logic {WAIT, UPDATE} state_t;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] gapX;
    logic [9:0] gapW;
  } floor_t;

  // Right-shifting Galois form: feedback taps applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction
endpackage

// File: rtl/floor_lfsr.sv
// Free-running 16-bit Galois LFSR; steps every clock so gaps depend on player timing.
module floor_lfsr
  import floors_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= lfsrNext(state);
  end
endmodule

// File: rtl/floor_slot.sv
// One floor: geometry registers, scroll/recycle update and pixel hit test.
// Gap drift is built when FLOORS_GAP_DRIFT_EN is defined.
module floor_slot
  import floors_pkg::*;
#(
  parameter int IDX         = 0,
  parameter int SPACING     = 160,
  parameter int FLOOR_THICK = 8,
  parameter int GAP_MIN     = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic [2:0]  speed,
  input  logic [14:0] rnd,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  output floor_t      geom,
  output logic        wrap,
  output logic        hit
);
  localparam logic [9:0] Y_RST  = 10'((IDX + 1) * SPACING - FLOOR_THICK);
  localparam logic [9:0] GX_RST = 10'((IDX * SPACING) % 512);
  localparam logic [9:0] GW_RST = 10'(GAP_MIN);

  logic [9:0] spd10;
  logic [9:0] gapXKeep;
  assign spd10 = {7'd0, speed};
  assign wrap  = geom.y < spd10;

`ifdef FLOORS_GAP_DRIFT_EN
  logic dirRight;
  logic atEdge;
  assign atEdge   = dirRight ? (geom.gapX == 10'd511) : (geom.gapX == 10'd0);
  assign gapXKeep = atEdge ? geom.gapX : (dirRight ? geom.gapX + 10'd1 : geom.gapX - 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       dirRight <= 1'((IDX % 2) == 0);
    else if (upd && !wrap && atEdge)  dirRight <= ~dirRight;
  end
`else
  assign gapXKeep = geom.gapX;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      geom <= '{y: Y_RST, gapX: GX_RST, gapW: GW_RST};
    end else if (upd) begin
      if (wrap) begin
        // y < speed here, so y + 480 - speed stays below 480
        geom.y    <= geom.y + 10'd480 - spd10;
        geom.gapX <= {1'b0, rnd[14:6]};
        geom.gapW <= GW_RST + {4'd0, rnd[5:0]};
      end else begin
        geom.y    <= geom.y - spd10;
        geom.gapX <= gapXKeep;
      end
    end
  end

  // 11-bit sums so a floor or gap near the top of the range never wraps
  logic [10:0] yEnd, gEnd, hc11, vc11;
  assign hc11 = {1'b0, hc};
  assign vc11 = {1'b0, vc};
  assign yEnd = {1'b0, geom.y} + 11'(FLOOR_THICK);
  assign gEnd = {1'b0, geom.gapX} + {1'b0, geom.gapW};
  assign hit  = (vc11 >= {1'b0, geom.y}) && (vc11 < yEnd) &&
                !((hc11 >= {1'b0, geom.gapX}) && (hc11 < gEnd));
endmodule

// File: rtl/floor_field.sv
// Scrolling floor generator: per-frame update sequencer, recycle counter and registered pixel output.
// Optional gap drift enabled by defining FLOORS_GAP_DRIFT_EN.
module floor_field
  import floors_pkg::*;
#(
  parameter int          NUM_FLOORS  = 3,
  parameter int          FLOOR_THICK = 8,
  parameter int          SPACING     = 160,
  parameter int          GAP_MIN     = 40,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    run,
  input  logic [2:0]              speed,
  input  logic [9:0]              hc,
  input  logic [9:0]              vc,
  output logic [2:0]              r,
  output logic [2:0]              g,
  output logic [1:0]              b,
  output logic [10*NUM_FLOORS-1:0] floor_y,
  output logic [10*NUM_FLOORS-1:0] gap_x,
  output logic [10*NUM_FLOORS-1:0] gap_w,
  output logic                    busy,
  output logic                    wrap_pulse,
  output logic [15:0]             wrap_count
);
  localparam int IDX_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FLOORS - 1);

  state_t           state, stateNxt;
  logic [IDX_W-1:0] idx, idxNxt;
  logic [15:0]      lfsr;
  logic             unusedLfsrMsb;

  floor_t                geom [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] updVec, wrapVec, hitVec;

  floor_lfsr #(.SEED(LFSR_SEED)) uLfsr (.clk(clk), .rst_n(rst_n), .state(lfsr));
  assign unusedLfsrMsb = lfsr[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      idx   <= '0;
    end else begin
      state <= stateNxt;
      idx   <= idxNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    idxNxt   = idx;
    case (state)
      WAIT:
        if (frame_tick && run) begin
          stateNxt = UPDATE;
          idxNxt   = '0;
        end
      UPDATE:
        if (idx == LAST) begin
          stateNxt = WAIT;
          idxNxt   = '0;
        end else begin
          idxNxt = idx + IDX_W'(1);
        end
      default: stateNxt = WAIT;
    endcase
  end

  assign busy = (state == UPDATE);

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : gSlot
    floor_slot #(
      .IDX(i), .SPACING(SPACING), .FLOOR_THICK(FLOOR_THICK), .GAP_MIN(GAP_MIN)
    ) uSlot (
      .clk(clk), .rst_n(rst_n), .upd(updVec[i]), .speed(speed), .rnd(lfsr[14:0]),
      .hc(hc), .vc(vc), .geom(geom[i]), .wrap(wrapVec[i]), .hit(hitVec[i])
    );
    assign updVec[i]          = busy && (idx == IDX_W'(i));
    assign floor_y[10*i +: 10] = geom[i].y;
    assign gap_x[10*i +: 10]   = geom[i].gapX;
    assign gap_w[10*i +: 10]   = geom[i].gapW;
  end

  logic anyWrap;
  assign anyWrap = |(updVec & wrapVec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      wrap_pulse <= anyWrap;
      if (anyWrap && (wrap_count != 16'hFFFF)) wrap_count <= wrap_count + 16'd1;
    end
  end

  rgb_t pix;
  logic onScreen;
  assign onScreen = (hc < 10'(SCREEN_W)) && (vc < 10'(SCREEN_H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix <= BG_RGB;
    else        pix <= ((|hitVec) && onScreen) ? FLOOR_RGB : BG_RGB;
  end

  assign r = pix.r;
  assign g = pix.g;
  assign b = pix.b;
endmodule
